// File: rtl/axi_burst_master.sv
// AXI4 burst manager moving 16-bit samples between local streams and an AXI subordinate.
// Commands are split into INCR bursts that never cross 4 KB, one transaction outstanding.
module axi_burst_master #(
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 14
) (
  input  logic              a_clk,
  input  logic              a_rst,
  input  logic              cmd_start,
  input  logic              cmd_rd,
  input  logic [31:0]       cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [31:0]       a_awaddr,
  output logic [7:0]        a_awlen,
  output logic [2:0]        a_awsize,
  output logic [1:0]        a_awburst,
  output logic              a_awvalid,
  input  logic              a_awready,
  output logic              a_wvalid,
  input  logic              a_wready,
  output logic [63:0]       a_wdata,
  output logic [7:0]        a_wstrb,
  output logic              a_wlast,
  input  logic              a_bvalid,
  output logic              a_bready,
  input  logic [1:0]        a_bresp,
  output logic [31:0]       a_araddr,
  output logic [7:0]        a_arlen,
  output logic [2:0]        a_arsize,
  output logic [1:0]        a_arburst,
  output logic              a_arvalid,
  input  logic              a_arready,
  input  logic              a_rvalid,
  output logic              a_rready,
  input  logic [63:0]       a_rdata,
  input  logic [1:0]        a_rresp,
  input  logic              a_rlast
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R, ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [7:0]         len_q, len_d;
  logic [8:0]         cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [8:0]         beats;
  logic [LEN_W-1:0]   rem_after;
  logic [31:0]        next_addr;
  logic               last_beat;
  logic               in_w, in_r;
  logic               unused_rdata;

  // Burst length minus one: limited by remaining samples, MAX_BURST and the 4 KB page edge.
  function automatic logic [7:0] calc_len(input logic [31:0] addr, input logic [LEN_W-1:0] rem);
    logic [12:0] bytes_left;
    logic [15:0] lim;
    bytes_left = 13'd4096 - {1'b0, addr[11:0]};
    lim = 16'(MAX_BURST);
    if ({6'd0, bytes_left[12:3]} < lim) lim = {6'd0, bytes_left[12:3]};
    if (16'(rem) < lim) lim = 16'(rem);
    return 8'(lim - 16'd1);
  endfunction

  assign beats     = {1'b0, len_q} + 9'd1;
  assign rem_after = rem_q - LEN_W'(beats);
  assign next_addr = addr_q + 32'({beats, 3'b000});
  assign last_beat = (cnt_q == {1'b0, len_q});

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          err_d  = 1'b0;
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          cnt_d  = '0;
          if (cmd_len == '0) begin
            state_d = ST_DONE;
          end else begin
            len_d   = calc_len(cmd_addr, cmd_len);
            state_d = cmd_rd ? ST_AR : ST_AW;
          end
        end
      end
      ST_AW: if (a_awready) state_d = ST_W;
      ST_W: begin
        if (s_valid && a_wready) begin
          cnt_d = cnt_q + 9'd1;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = ST_B;
          end
        end
      end
      ST_B: begin
        if (a_bvalid) begin
          if (a_bresp != 2'b00) err_d = 1'b1;
          rem_d = rem_after;
          if (rem_after == '0) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = next_addr;
            len_d   = calc_len(next_addr, rem_after);
            state_d = ST_AW;
          end
        end
      end
      ST_AR: if (a_arready) state_d = ST_R;
      ST_R: begin
        if (a_rvalid && m_ready) begin
          cnt_d = cnt_q + 9'd1;
          if (a_rresp != 2'b00) err_d = 1'b1;
          if (a_rlast) begin
            // Short or long bursts are flagged but still retire the expected length.
            if (!last_beat) err_d = 1'b1;
            cnt_d = '0;
            rem_d = rem_after;
            if (rem_after == '0) begin
              state_d = ST_DONE;
            end else begin
              addr_d  = next_addr;
              len_d   = calc_len(next_addr, rem_after);
              state_d = ST_AR;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign in_w = (state_q == ST_W);
  assign in_r = (state_q == ST_R);

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign err  = err_q;

  assign a_awaddr  = addr_q;
  assign a_awlen   = len_q;
  assign a_awsize  = 3'b011;
  assign a_awburst = 2'b01;
  assign a_awvalid = (state_q == ST_AW);

  // Write data passes straight from the source stream; nothing is buffered.
  assign a_wvalid = in_w & s_valid;
  assign s_ready  = in_w & a_wready;
  assign a_wdata  = {{(64-DATA_W){1'b0}}, s_data};
  assign a_wstrb  = 8'h03;
  assign a_wlast  = in_w & last_beat;
  assign a_bready = (state_q == ST_B);

  assign a_araddr  = addr_q;
  assign a_arlen   = len_q;
  assign a_arsize  = 3'b011;
  assign a_arburst = 2'b01;
  assign a_arvalid = (state_q == ST_AR);

  assign m_valid  = in_r & a_rvalid;
  assign a_rready = in_r & m_ready;
  assign m_data   = in_r ? a_rdata[DATA_W-1:0] : '0;

  assign unused_rdata = ^a_rdata[63:DATA_W];

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master with a cycle-stepped AXI subordinate and stream models.
module tb_axi_burst_master;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 14;

  logic              a_clk = 1'b0;
  logic              a_rst;
  logic              cmd_start, cmd_rd;
  logic [31:0]       cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              busy, done, err;
  logic              s_valid, s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid, m_ready;
  logic [DATA_W-1:0] m_data;
  logic [31:0]       a_awaddr, a_araddr;
  logic [7:0]        a_awlen, a_arlen;
  logic [2:0]        a_awsize, a_arsize;
  logic [1:0]        a_awburst, a_arburst;
  logic              a_awvalid, a_awready, a_wvalid, a_wready, a_wlast;
  logic [63:0]       a_wdata, a_rdata;
  logic [7:0]        a_wstrb;
  logic              a_bvalid, a_bready, a_arvalid, a_arready;
  logic [1:0]        a_bresp, a_rresp;
  logic              a_rvalid, a_rready, a_rlast;

  axi_burst_master #(.DATA_W(DATA_W), .MAX_BURST(16), .LEN_W(LEN_W)) dut (
    .a_clk(a_clk), .a_rst(a_rst),
    .cmd_start(cmd_start), .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .a_awaddr(a_awaddr), .a_awlen(a_awlen), .a_awsize(a_awsize), .a_awburst(a_awburst),
    .a_awvalid(a_awvalid), .a_awready(a_awready),
    .a_wvalid(a_wvalid), .a_wready(a_wready), .a_wdata(a_wdata), .a_wstrb(a_wstrb),
    .a_wlast(a_wlast),
    .a_bvalid(a_bvalid), .a_bready(a_bready), .a_bresp(a_bresp),
    .a_araddr(a_araddr), .a_arlen(a_arlen), .a_arsize(a_arsize), .a_arburst(a_arburst),
    .a_arvalid(a_arvalid), .a_arready(a_arready),
    .a_rvalid(a_rvalid), .a_rready(a_rready), .a_rdata(a_rdata), .a_rresp(a_rresp),
    .a_rlast(a_rlast)
  );

  always #5 a_clk = ~a_clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] req_addr_q[$];
  logic [7:0]  req_len_q[$];
  logic [63:0] wdata_q[$];
  logic        wlast_q[$];
  logic [7:0]  wstrb_q[$];
  logic [15:0] rd_q[$];

  logic        b_pending, done_seen, any_valid, done_busy, done_err;
  int          burst_no, r_left, done_cycle, last_resp_cycle, first_req_cycle;
  logic [15:0] w_sample, r_val;
  logic [31:0] exp_addr[3];
  logic [7:0]  exp_len[3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one command and plays subordinate plus stream endpoints until done (bounded).
  task automatic do_cmd(input logic rd, input logic [31:0] addr, input logic [LEN_W-1:0] len,
                        input int bad_burst, input logic toggle);
    req_addr_q.delete(); req_len_q.delete();
    wdata_q.delete(); wlast_q.delete(); wstrb_q.delete(); rd_q.delete();
    b_pending = 1'b0; burst_no = 0; r_left = 0;
    w_sample = 16'hA000; r_val = 16'h5000;
    done_seen = 1'b0; any_valid = 1'b0; done_busy = 1'b0; done_err = 1'b0;
    done_cycle = -1; last_resp_cycle = -1; first_req_cycle = -1;
    @(negedge a_clk);
    cmd_rd = rd; cmd_addr = addr; cmd_len = len; cmd_start = 1'b1;
    @(negedge a_clk);
    cmd_start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      a_bvalid = b_pending;
      a_bresp  = (burst_no == bad_burst) ? 2'b10 : 2'b00;
      a_rvalid = (r_left > 0);
      a_rlast  = (r_left == 1);
      a_rdata  = {48'hFFFF_FFFF_FFFF, r_val};
      m_ready  = toggle ? (c % 2 == 0) : 1'b1;
      s_data   = w_sample;
      #1;
      if (a_awvalid || a_arvalid || a_wvalid || m_valid) any_valid = 1'b1;
      if ((a_awvalid || a_arvalid) && first_req_cycle < 0) first_req_cycle = c;
      if (a_awvalid && a_awready) begin
        req_addr_q.push_back(a_awaddr); req_len_q.push_back(a_awlen);
      end
      if (a_arvalid && a_arready) begin
        req_addr_q.push_back(a_araddr); req_len_q.push_back(a_arlen);
        r_left = int'(a_arlen) + 1;
      end
      if (a_wvalid && a_wready) begin
        wdata_q.push_back(a_wdata); wlast_q.push_back(a_wlast); wstrb_q.push_back(a_wstrb);
        w_sample++;
        if (a_wlast) b_pending = 1'b1;
      end
      if (a_bvalid && a_bready) begin
        b_pending = 1'b0; burst_no++; last_resp_cycle = c;
      end
      if (a_rvalid) check("rready_follows_m_ready", a_rready, m_ready);
      if (m_valid && m_ready) begin
        rd_q.push_back(m_data);
        if (a_rlast) last_resp_cycle = c;
        r_left--; r_val++;
      end
      if (done) begin
        done_seen = 1'b1; done_cycle = c; done_busy = busy; done_err = err;
        break;
      end
      @(negedge a_clk);
    end
    check("done_seen", done_seen, 1'b1);
    @(negedge a_clk);
    a_bvalid = 1'b0; a_rvalid = 1'b0; a_rlast = 1'b0;
    #1;
    check("done_one_cycle", done, 1'b0);
    check("idle_busy_low", busy, 1'b0);
  endtask

  initial begin
    a_rst = 1'b1;
    cmd_start = 1'b0; cmd_rd = 1'b0; cmd_addr = '0; cmd_len = '0;
    s_valid = 1'b1; s_data = '0; m_ready = 1'b1;
    a_awready = 1'b1; a_wready = 1'b1; a_arready = 1'b1;
    a_bvalid = 1'b0; a_bresp = 2'b00;
    a_rvalid = 1'b0; a_rdata = '0; a_rresp = 2'b00; a_rlast = 1'b0;
    repeat (3) @(negedge a_clk);
    #1;
    check("reset_ctrl", {busy, done, err, a_awvalid, a_arvalid, a_wvalid, a_wlast,
                         a_bready, a_rready, s_ready, m_valid}, 11'd0);
    check("reset_addr_len", {a_awaddr, a_awlen}, 40'd0);
    check("reset_m_data", m_data, 16'd0);
    a_rst = 1'b0;

    // 1: single 4-beat write burst
    do_cmd(1'b0, 32'h0, 14'd4, -1, 1'b0);
    check("t1_first_aw_latency", first_req_cycle, 0);
    check("t1_aw_count", req_addr_q.size(), 1);
    check("t1_awaddr", req_addr_q[0], 32'h0);
    check("t1_awlen", req_len_q[0], 8'd3);
    check("t1_awsize_burst", {a_awsize, a_awburst, a_arsize, a_arburst}, 10'b011_01_011_01);
    check("t1_w_beats", wdata_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_wdata%0d", i), wdata_q[i], {48'd0, 16'hA000 + 16'(i)});
      check($sformatf("t1_wlast%0d", i), wlast_q[i], (i == 3));
      check($sformatf("t1_wstrb%0d", i), wstrb_q[i], 8'h03);
    end
    check("t1_done_after_b", done_cycle, last_resp_cycle + 1);
    check("t1_busy_in_done", done_busy, 1'b1);
    check("t1_err", done_err, 1'b0);

    // 2: 40 samples -> 16,16,8
    do_cmd(1'b0, 32'h0, 14'd40, -1, 1'b0);
    exp_addr = '{32'h000, 32'h080, 32'h100};
    exp_len  = '{8'd15, 8'd15, 8'd7};
    check("t2_aw_count", req_addr_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_awaddr%0d", i), req_addr_q[i], exp_addr[i]);
      check($sformatf("t2_awlen%0d", i), req_len_q[i], exp_len[i]);
    end
    check("t2_w_beats", wdata_q.size(), 40);
    for (int i = 0; i < 40; i++) begin
      check($sformatf("t2_wdata%0d", i), wdata_q[i], {48'd0, 16'hA000 + 16'(i)});
      check($sformatf("t2_wlast%0d", i), wlast_q[i], (i == 15 || i == 31 || i == 39));
    end
    check("t2_done_after_b", done_cycle, last_resp_cycle + 1);

    // 3: 4 KB page split
    do_cmd(1'b0, 32'hFE0, 14'd8, -1, 1'b0);
    exp_addr = '{32'hFE0, 32'h1000, 32'h0};
    check("t3_aw_count", req_addr_q.size(), 2);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t3_awaddr%0d", i), req_addr_q[i], exp_addr[i]);
      check($sformatf("t3_awlen%0d", i), req_len_q[i], 8'd3);
    end
    check("t3_w_beats", wdata_q.size(), 8);

    // 4: read with m_ready toggling
    do_cmd(1'b1, 32'h40, 14'd20, -1, 1'b1);
    exp_addr = '{32'h040, 32'h0C0, 32'h0};
    exp_len  = '{8'd15, 8'd3, 8'd0};
    check("t4_first_ar_latency", first_req_cycle, 0);
    check("t4_ar_count", req_addr_q.size(), 2);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t4_araddr%0d", i), req_addr_q[i], exp_addr[i]);
      check($sformatf("t4_arlen%0d", i), req_len_q[i], exp_len[i]);
    end
    check("t4_samples", rd_q.size(), 20);
    for (int i = 0; i < 20; i++)
      check($sformatf("t4_m_data%0d", i), rd_q[i], 16'h5000 + 16'(i));
    check("t4_no_wr_beats", wdata_q.size(), 0);
    check("t4_done_after_rlast", done_cycle, last_resp_cycle + 1);
    check("t4_err", done_err, 1'b0);

    // 5: error response on first burst does not abort
    do_cmd(1'b0, 32'h200, 14'd32, 0, 1'b0);
    check("t5_aw_count", req_addr_q.size(), 2);
    check("t5_awaddr1", req_addr_q[1], 32'h280);
    check("t5_w_beats", wdata_q.size(), 32);
    check("t5_err_at_done", done_err, 1'b1);
    repeat (2) @(negedge a_clk);
    #1;
    check("t5_err_held", err, 1'b1);

    // 6a: zero length, also clears err
    do_cmd(1'b0, 32'h0, 14'd0, -1, 1'b0);
    check("t6_done_latency", done_cycle, 0);
    check("t6_no_axi_valid", any_valid, 1'b0);
    check("t6_err_cleared", done_err, 1'b0);

    // 6b: reset in the middle of a write burst
    @(negedge a_clk);
    cmd_rd = 1'b0; cmd_addr = 32'h0; cmd_len = 14'd4; cmd_start = 1'b1;
    @(negedge a_clk);
    cmd_start = 1'b0;
    @(negedge a_clk);
    #1;
    check("t6_pre_rst_wvalid", {a_wvalid, s_ready, busy}, 3'b111);
    a_rst = 1'b1;
    #1;
    check("t6_rst_outputs", {a_wvalid, s_ready, busy, a_awvalid, a_wlast}, 5'd0);
    @(negedge a_clk);
    a_rst = 1'b0;
    @(negedge a_clk);
    #1;
    check("t6_post_rst_idle", {busy, done, a_awvalid, a_wvalid}, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
